// File: rtl/infra_reset_sequencer_pkg.sv
// Shared types and constants for the board reset sequencer.
// Debug-visible state encodings are fixed values.
package infra_reset_pkg;

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        SETTLE    = 3'd1,
        IDLY_RST  = 3'd2,
        IDLY_WAIT = 3'd3,
        RELEASE   = 3'd4,
        RUN       = 3'd5
    } seq_state_e;

    localparam logic [3:0] RETRY_MAX = 4'd15;

    function automatic logic [3:0] retry_inc(input logic [3:0] v);
        return (v == RETRY_MAX) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/infra_reset_sequencer_if.sv
// Signals between the clock infrastructure and the reset sequencer.
// The master side is the sequencer; the slave side is the infrastructure/fabric.
interface infra_reset_sequencer_if;

    logic       sys_clk_lock;
    logic       idelay_rdy;
    logic       idelay_rst;
    logic       sys_rst;
    logic       ready;
    logic [2:0] state;
    logic [3:0] retry_cnt;
    logic       timeout_seen;

    modport master (
        input  sys_clk_lock,
        input  idelay_rdy,
        output idelay_rst,
        output sys_rst,
        output ready,
        output state,
        output retry_cnt,
        output timeout_seen
    );

    modport slave (
        output sys_clk_lock,
        output idelay_rdy,
        input  idelay_rst,
        input  sys_rst,
        input  ready,
        input  state,
        input  retry_cnt,
        input  timeout_seen
    );

endinterface

// File: rtl/infra_reset_sequencer_sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs.
// Both stages clear to 0 on reset.
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/infra_reset_sequencer.sv
// Brings the fabric out of reset after MMCM lock and IDELAYCTRL calibration,
// re-sequencing on lock loss and retrying IDELAY reset on calibration timeout.
module infra_reset_sequencer
    import infra_reset_pkg::*;
#(
    parameter int unsigned LOCK_STABLE_CYCLES = 1024,
    parameter int unsigned IDELAY_RST_CYCLES  = 16,
    parameter int unsigned IDELAY_TIMEOUT     = 4096,
    parameter int unsigned RELEASE_DELAY      = 64,
    parameter int unsigned CNT_W              = 16
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst_n,
    infra_reset_sequencer_if.master bus
);

    localparam longint unsigned CNT_LIM = 64'd1 << CNT_W;

    if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
        $error("CNT_W out of range");
    end
    if (LOCK_STABLE_CYCLES < 1 || LOCK_STABLE_CYCLES >= CNT_LIM) begin : g_bad_lock
        $error("LOCK_STABLE_CYCLES out of range for CNT_W");
    end
    if (IDELAY_RST_CYCLES < 1 || IDELAY_RST_CYCLES >= CNT_LIM) begin : g_bad_rst
        $error("IDELAY_RST_CYCLES out of range for CNT_W");
    end
    if (IDELAY_TIMEOUT < 1 || IDELAY_TIMEOUT >= CNT_LIM) begin : g_bad_tmo
        $error("IDELAY_TIMEOUT out of range for CNT_W");
    end
    if (RELEASE_DELAY < 1 || RELEASE_DELAY >= CNT_LIM) begin : g_bad_rel
        $error("RELEASE_DELAY out of range for CNT_W");
    end

    localparam logic [CNT_W-1:0] LOCK_LOAD = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RST_LOAD  = CNT_W'(IDELAY_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LOAD  = CNT_W'(IDELAY_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] REL_LOAD  = CNT_W'(RELEASE_DELAY - 1);

    logic [1:0]       sync_q;
    logic             lock_s;
    logic             rdy_s;

    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       retry_q, retry_d;
    logic             seen_q, seen_d;
    logic             cnt_zero;

    logic             idelay_rst_q;
    logic             sys_rst_q;
    logic             ready_q;

    sync_2ff #(.WIDTH(2)) u_sync (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .d     ({bus.idelay_rdy, bus.sys_clk_lock}),
        .q     (sync_q)
    );

    assign lock_s   = sync_q[0];
    assign rdy_s    = sync_q[1];
    assign cnt_zero = (cnt_q == '0);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= WAIT_LOCK;
            cnt_q        <= '0;
            retry_q      <= '0;
            seen_q       <= 1'b0;
            idelay_rst_q <= 1'b0;
            sys_rst_q    <= 1'b1;
            ready_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            retry_q      <= retry_d;
            seen_q       <= seen_d;
            idelay_rst_q <= (state_d == IDLY_RST);
            sys_rst_q    <= (state_d != RUN);
            ready_q      <= (state_d == RUN);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        seen_d  = seen_q;

        case (state_q)
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = SETTLE;
                    cnt_d   = LOCK_LOAD;
                end
            end
            SETTLE: begin
                if (cnt_zero) begin
                    state_d = IDLY_RST;
                    cnt_d   = RST_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            IDLY_RST: begin
                if (cnt_zero) begin
                    state_d = IDLY_WAIT;
                    cnt_d   = TMO_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            IDLY_WAIT: begin
                // Ready seen on the final timeout cycle still counts as success.
                if (rdy_s) begin
                    state_d = RELEASE;
                    cnt_d   = REL_LOAD;
                end else if (cnt_zero) begin
                    state_d = IDLY_RST;
                    cnt_d   = RST_LOAD;
                    retry_d = retry_inc(retry_q);
                    seen_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RELEASE: begin
                if (cnt_zero) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RUN: begin
                state_d = RUN;
            end
            default: begin
                state_d = WAIT_LOCK;
            end
        endcase

        // Lock loss wins over every transition, including a coincident timeout.
        if (state_q != WAIT_LOCK && !lock_s) begin
            state_d = WAIT_LOCK;
            cnt_d   = cnt_q;
            retry_d = retry_q;
            seen_d  = seen_q;
        end
    end

    assign bus.idelay_rst   = idelay_rst_q;
    assign bus.sys_rst      = sys_rst_q;
    assign bus.ready        = ready_q;
    assign bus.state        = state_q;
    assign bus.retry_cnt    = retry_q;
    assign bus.timeout_seen = seen_q;

endmodule

// File: tb/tb_infra_reset_sequencer.sv
// Directed bench for infra_reset_sequencer with parameters 8/4/20/6.
// Cycle offsets are counted from the posedge preceding each stimulus change.
module tb_infra_reset_sequencer;

    logic sys_clk = 1'b0;
    logic sys_rst_n;
    int   n_cmp  = 0;
    int   n_fail = 0;

    infra_reset_sequencer_if bus ();

    infra_reset_sequencer #(
        .LOCK_STABLE_CYCLES (8),
        .IDELAY_RST_CYCLES  (4),
        .IDELAY_TIMEOUT     (20),
        .RELEASE_DELAY      (6),
        .CNT_W              (16)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic step(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        bus.sys_clk_lock = 1'b0;
        bus.idelay_rdy   = 1'b0;
        sys_rst_n        = 1'b1;
        #1 sys_rst_n     = 1'b0;
        #12;
        chk("rst_idelay_rst", 16'(bus.idelay_rst), 16'd0);
        chk("rst_sys_rst",    16'(bus.sys_rst),    16'd1);
        chk("rst_ready",      16'(bus.ready),      16'd0);
        chk("rst_state",      16'(bus.state),      16'd0);
        chk("rst_retry",      16'(bus.retry_cnt),  16'd0);
        chk("rst_seen",       16'(bus.timeout_seen), 16'd0);

        @(posedge sys_clk); #1;
        sys_rst_n = 1'b1;
        step(1);

        // Nominal bring-up.
        bus.sys_clk_lock = 1'b1;
        step(10);
        chk("nom_t10_idelay_rst", 16'(bus.idelay_rst), 16'd0);
        chk("nom_t10_state",      16'(bus.state),      16'd1);
        step(1);
        chk("nom_t11_idelay_rst", 16'(bus.idelay_rst), 16'd1);
        chk("nom_t11_state",      16'(bus.state),      16'd2);
        chk("nom_t11_sys_rst",    16'(bus.sys_rst),    16'd1);
        step(3);
        chk("nom_t14_idelay_rst", 16'(bus.idelay_rst), 16'd1);
        step(1);
        chk("nom_t15_idelay_rst", 16'(bus.idelay_rst), 16'd0);
        chk("nom_t15_state",      16'(bus.state),      16'd3);
        step(5);
        bus.idelay_rdy = 1'b1;
        step(8);
        chk("nom_rel_sys_rst", 16'(bus.sys_rst), 16'd1);
        chk("nom_rel_state",   16'(bus.state),   16'd4);
        chk("nom_rel_ready",   16'(bus.ready),   16'd0);
        step(1);
        chk("nom_run_sys_rst", 16'(bus.sys_rst),   16'd0);
        chk("nom_run_ready",   16'(bus.ready),     16'd1);
        chk("nom_run_state",   16'(bus.state),     16'd5);
        chk("nom_run_retry",   16'(bus.retry_cnt), 16'd0);
        chk("nom_run_seen",    16'(bus.timeout_seen), 16'd0);

        // Lock lost in RUN, then relock with ready already high.
        step(3);
        bus.sys_clk_lock = 1'b0;
        step(2);
        chk("loss_e2_sys_rst", 16'(bus.sys_rst), 16'd0);
        chk("loss_e2_ready",   16'(bus.ready),   16'd1);
        step(1);
        chk("loss_e3_sys_rst", 16'(bus.sys_rst), 16'd1);
        chk("loss_e3_ready",   16'(bus.ready),   16'd0);
        chk("loss_e3_state",   16'(bus.state),   16'd0);
        step(2);
        bus.sys_clk_lock = 1'b1;
        step(11);
        chk("relock_idelay_rst", 16'(bus.idelay_rst), 16'd1);
        step(10);
        chk("relock_rel_state",   16'(bus.state),   16'd4);
        chk("relock_rel_sys_rst", 16'(bus.sys_rst), 16'd1);
        step(1);
        chk("relock_run_ready",   16'(bus.ready),     16'd1);
        chk("relock_run_sys_rst", 16'(bus.sys_rst),   16'd0);
        chk("relock_run_retry",   16'(bus.retry_cnt), 16'd0);

        // IDELAY never ready: periodic retries with saturating count.
        bus.sys_clk_lock = 1'b0;
        bus.idelay_rdy   = 1'b0;
        step(4);
        chk("retry_idle_state", 16'(bus.state), 16'd0);
        bus.sys_clk_lock = 1'b1;
        step(11);
        chk("retry_p0_idelay_rst", 16'(bus.idelay_rst), 16'd1);
        chk("retry_p0_state",      16'(bus.state),      16'd2);
        step(23);
        chk("retry_pre1_state", 16'(bus.state),        16'd3);
        chk("retry_pre1_retry", 16'(bus.retry_cnt),    16'd0);
        chk("retry_pre1_seen",  16'(bus.timeout_seen), 16'd0);
        step(1);
        chk("retry_p1_idelay_rst", 16'(bus.idelay_rst),   16'd1);
        chk("retry_p1_retry",      16'(bus.retry_cnt),    16'd1);
        chk("retry_p1_seen",       16'(bus.timeout_seen), 16'd1);
        for (int k = 2; k <= 17; k++) begin
            step(23);
            chk("retry_gap_idelay_rst", 16'(bus.idelay_rst), 16'd0);
            chk("retry_gap_sys_rst",    16'(bus.sys_rst),    16'd1);
            step(1);
            chk("retry_pulse_idelay_rst", 16'(bus.idelay_rst), 16'd1);
            chk("retry_pulse_cnt", 16'(bus.retry_cnt), (k > 15) ? 16'd15 : 16'(k));
        end

        // Lock fall and ready rise land on the same cycle in IDLY_WAIT.
        step(5);
        bus.sys_clk_lock = 1'b0;
        bus.idelay_rdy   = 1'b1;
        step(2);
        chk("race_pre_state", 16'(bus.state), 16'd3);
        step(1);
        chk("race_state",   16'(bus.state),        16'd0);
        chk("race_sys_rst", 16'(bus.sys_rst),      16'd1);
        chk("race_retry",   16'(bus.retry_cnt),    16'd15);
        chk("race_seen",    16'(bus.timeout_seen), 16'd1);

        // Single-cycle lock glitch at settle count 5 restarts settling.
        step(2);
        bus.sys_clk_lock = 1'b1;
        step(3);
        chk("glitch_settle_state", 16'(bus.state), 16'd1);
        bus.sys_clk_lock = 1'b0;
        step(1);
        bus.sys_clk_lock = 1'b1;
        step(1);
        chk("glitch_j5_state", 16'(bus.state), 16'd1);
        step(1);
        chk("glitch_j6_state", 16'(bus.state), 16'd0);
        step(1);
        chk("glitch_j7_state", 16'(bus.state), 16'd1);
        step(7);
        chk("glitch_j14_state",      16'(bus.state),      16'd1);
        chk("glitch_j14_idelay_rst", 16'(bus.idelay_rst), 16'd0);
        step(1);
        chk("glitch_j15_state",      16'(bus.state),      16'd2);
        chk("glitch_j15_idelay_rst", 16'(bus.idelay_rst), 16'd1);

        // Asynchronous reset in the middle of RELEASE.
        step(7);
        chk("mid_rel_state",   16'(bus.state),   16'd4);
        chk("mid_rel_sys_rst", 16'(bus.sys_rst), 16'd1);
        sys_rst_n = 1'b0;
        #2;
        chk("arst_idelay_rst", 16'(bus.idelay_rst),   16'd0);
        chk("arst_sys_rst",    16'(bus.sys_rst),      16'd1);
        chk("arst_ready",      16'(bus.ready),        16'd0);
        chk("arst_state",      16'(bus.state),        16'd0);
        chk("arst_retry",      16'(bus.retry_cnt),    16'd0);
        chk("arst_seen",       16'(bus.timeout_seen), 16'd0);
        step(1);
        sys_rst_n = 1'b1;
        step(10);
        chk("post_t10_state",      16'(bus.state),      16'd1);
        chk("post_t10_idelay_rst", 16'(bus.idelay_rst), 16'd0);
        step(1);
        chk("post_t11_state",      16'(bus.state),      16'd2);
        chk("post_t11_idelay_rst", 16'(bus.idelay_rst), 16'd1);
        chk("post_t11_retry",      16'(bus.retry_cnt),  16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
